// File: rtl/uart_reg_master.sv
// rtl/uart_reg_master.sv - register-bus initiator driving the uart_core register port for a stream client
// Optional TX watchdog and sticky err_o are built only with UART_MASTER_TIMEOUT_EN defined.
module uart_reg_master #(
    parameter int MAX_BURST  = 7,
    parameter int READ_LAT   = 1
`ifdef UART_MASTER_TIMEOUT_EN
    ,
    parameter int TX_TIMEOUT = 65535
`endif
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [15:0] cfg_baud_i,
    input  logic        cfg_rx_en_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    input  logic [7:0]  tx_byte_i,
    input  logic        tx_last_i,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic [7:0]  rx_byte_o,
    input  logic        intr_tx_i,
    input  logic        intr_rx_i,
    input  logic        intr_rx_empty_i,
    output logic [11:0] reg_addr_o,
    output logic [31:0] reg_wdata_o,
    output logic        reg_we_o,
    output logic        reg_re_o,
    input  logic [31:0] reg_rdata_i,
    output logic        busy_o,
    output logic        err_o
);

    localparam logic [11:0] A_BAUD     = 12'h000;
    localparam logic [11:0] A_TX_DATA  = 12'h004;
    localparam logic [11:0] A_RX_DATA  = 12'h008;
    localparam logic [11:0] A_RX_EN    = 12'h00C;
    localparam logic [11:0] A_TX_CLR   = 12'h010;
    localparam logic [11:0] A_RX_CLR   = 12'h014;
    localparam logic [11:0] A_TX_LEVEL = 12'h018;
    localparam logic [11:0] A_RD_EN    = 12'h01C;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_TX_DATA, S_TX_PUSH, S_TX_LEVEL, S_TX_LGAP,
        S_TX_KICK, S_TX_WAIT, S_TX_DONE, S_RX_REQ, S_RX_CAP, S_RX_OUT
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_step, w_step_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic        r_last, w_last_nxt;
    logic [1:0]  r_lat, w_lat_nxt;
    logic        r_rx_en, w_rx_en_nxt;
    logic        r_cfg_rx_en, w_cfg_rx_en_nxt;
    logic [7:0]  r_rx_byte, w_rx_byte_nxt;
    logic [11:0] r_addr, w_addr_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic        r_we, w_we_nxt;
    logic        r_re, w_re_nxt;
    logic        w_tx_done_go;
    logic [2:0]  w_cfg_idx;
    logic [11:0] w_cfg_addr;
    logic [31:0] w_cfg_wdata;
    logic [23:0] w_unused_rdata;
`ifdef UART_MASTER_TIMEOUT_EN
    logic [15:0] r_wdog, w_wdog_nxt;
    logic        r_err, w_err_nxt;
`endif

    assign w_unused_rdata = reg_rdata_i[31:8];

    // CFG writes issue on odd steps for the following (even) step; the first is launched from IDLE.
    always_comb begin
        w_cfg_idx   = (r_state == S_CFG) ? 3'((r_step + 4'd1) >> 1) : 3'd0;
        w_cfg_addr  = A_RX_CLR;
        w_cfg_wdata = 32'h0;
        case (w_cfg_idx)
            3'd0: begin w_cfg_addr = A_BAUD;   w_cfg_wdata = {16'h0, cfg_baud_i};   end
            3'd1: begin w_cfg_addr = A_RX_EN;  w_cfg_wdata = {31'h0, r_cfg_rx_en};  end
            3'd2: begin w_cfg_addr = A_TX_CLR; w_cfg_wdata = 32'h1;                 end
            3'd3: begin w_cfg_addr = A_TX_CLR; w_cfg_wdata = 32'h0;                 end
            3'd4: begin w_cfg_addr = A_RX_CLR; w_cfg_wdata = 32'h1;                 end
            default: begin w_cfg_addr = A_RX_CLR; w_cfg_wdata = 32'h0;              end
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_step_nxt      = r_step;
        w_cnt_nxt       = r_cnt;
        w_last_nxt      = r_last;
        w_lat_nxt       = r_lat;
        w_rx_en_nxt     = r_rx_en;
        w_cfg_rx_en_nxt = r_cfg_rx_en;
        w_rx_byte_nxt   = r_rx_byte;
        w_addr_nxt      = 12'h000;
        w_wdata_nxt     = 32'h0;
        w_we_nxt        = 1'b0;
        w_re_nxt        = 1'b0;
        w_tx_done_go    = 1'b0;
        cfg_ready_o     = 1'b0;
        tx_ready_o      = 1'b0;
`ifdef UART_MASTER_TIMEOUT_EN
        w_wdog_nxt      = r_wdog;
        w_err_nxt       = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                cfg_ready_o = rst_ni;
                if (cfg_valid_i) begin
                    w_state_nxt     = S_CFG;
                    w_step_nxt      = 4'd0;
                    w_cfg_rx_en_nxt = cfg_rx_en_i;
                    w_we_nxt        = 1'b1;
                    w_addr_nxt      = w_cfg_addr;
                    w_wdata_nxt     = w_cfg_wdata;
                end else begin
                    tx_ready_o = rst_ni;
                    if (tx_valid_i) begin
                        w_state_nxt = S_TX_DATA;
                        w_cnt_nxt   = 3'd1;
                        w_last_nxt  = tx_last_i;
                        w_we_nxt    = 1'b1;
                        w_addr_nxt  = A_TX_DATA;
                        w_wdata_nxt = {24'h0, tx_byte_i};
                    end else if (intr_rx_i && !intr_rx_empty_i && r_rx_en) begin
                        w_state_nxt = S_RX_REQ;
                        w_re_nxt    = 1'b1;
                        w_addr_nxt  = A_RX_DATA;
                    end
                end
            end
            S_CFG: begin
                w_step_nxt = r_step + 4'd1;
                if (r_step == 4'd11) begin
                    w_state_nxt = S_IDLE;
                    w_rx_en_nxt = r_cfg_rx_en;
`ifdef UART_MASTER_TIMEOUT_EN
                    w_err_nxt   = 1'b0;
`endif
                end else if (r_step[0]) begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = w_cfg_addr;
                    w_wdata_nxt = w_cfg_wdata;
                end
            end
            S_TX_DATA: w_state_nxt = S_TX_PUSH;
            S_TX_PUSH: begin
                // A full burst closes even if the client never flagged tx_last_i.
                if (r_last || (r_cnt == 3'(MAX_BURST))) begin
                    w_state_nxt = S_TX_LEVEL;
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = A_TX_LEVEL;
                    w_wdata_nxt = {29'h0, r_cnt};
                end else begin
                    tx_ready_o = rst_ni;
                    if (tx_valid_i) begin
                        w_state_nxt = S_TX_DATA;
                        w_cnt_nxt   = r_cnt + 3'd1;
                        w_last_nxt  = tx_last_i;
                        w_we_nxt    = 1'b1;
                        w_addr_nxt  = A_TX_DATA;
                        w_wdata_nxt = {24'h0, tx_byte_i};
                    end
                end
            end
            S_TX_LEVEL: w_state_nxt = S_TX_LGAP;
            S_TX_LGAP: begin
                w_state_nxt = S_TX_KICK;
                w_we_nxt    = 1'b1;
                w_addr_nxt  = A_RD_EN;
                w_wdata_nxt = 32'h1;
            end
            S_TX_KICK: begin
                w_state_nxt = S_TX_WAIT;
`ifdef UART_MASTER_TIMEOUT_EN
                w_wdog_nxt  = 16'h0;
`endif
            end
            S_TX_WAIT: begin
                if (intr_tx_i) begin
                    w_tx_done_go = 1'b1;
                end
`ifdef UART_MASTER_TIMEOUT_EN
                else if (r_wdog == 16'(TX_TIMEOUT - 1)) begin
                    w_tx_done_go = 1'b1;
                    w_err_nxt    = 1'b1;
                end else begin
                    w_wdog_nxt = r_wdog + 16'd1;
                end
`endif
                if (w_tx_done_go) begin
                    w_state_nxt = S_TX_DONE;
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = A_RD_EN;
                    w_wdata_nxt = 32'h0;
                end
            end
            S_TX_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 3'd0;
                w_last_nxt  = 1'b0;
            end
            S_RX_REQ: begin
                w_state_nxt = S_RX_CAP;
                w_lat_nxt   = 2'd0;
            end
            S_RX_CAP: begin
                if (r_lat == 2'(READ_LAT - 1)) begin
                    w_rx_byte_nxt = reg_rdata_i[7:0];
                    w_state_nxt   = S_RX_OUT;
                end else begin
                    w_lat_nxt = r_lat + 2'd1;
                end
            end
            S_RX_OUT: begin
                if (rx_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_step      <= 4'd0;
            r_cnt       <= 3'd0;
            r_last      <= 1'b0;
            r_lat       <= 2'd0;
            r_rx_en     <= 1'b0;
            r_cfg_rx_en <= 1'b0;
            r_rx_byte   <= 8'h00;
            r_addr      <= 12'h000;
            r_wdata     <= 32'h0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
`ifdef UART_MASTER_TIMEOUT_EN
            r_wdog      <= 16'h0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_step      <= w_step_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last      <= w_last_nxt;
            r_lat       <= w_lat_nxt;
            r_rx_en     <= w_rx_en_nxt;
            r_cfg_rx_en <= w_cfg_rx_en_nxt;
            r_rx_byte   <= w_rx_byte_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_we        <= w_we_nxt;
            r_re        <= w_re_nxt;
`ifdef UART_MASTER_TIMEOUT_EN
            r_wdog      <= w_wdog_nxt;
            r_err       <= w_err_nxt;
`endif
        end
    end

    assign reg_addr_o  = r_addr;
    assign reg_wdata_o = r_wdata;
    assign reg_we_o    = r_we;
    assign reg_re_o    = r_re;
    assign rx_valid_o  = (r_state == S_RX_OUT);
    assign rx_byte_o   = r_rx_byte;
    assign busy_o      = (r_state != S_IDLE);
`ifdef UART_MASTER_TIMEOUT_EN
    assign err_o       = r_err;
`else
    assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_reg_master.sv
// tb/tb_uart_reg_master.sv - scoreboard bench for uart_reg_master register traffic and RX stream
// Timeout scenario runs only when UART_MASTER_TIMEOUT_EN is defined.
module tb_uart_reg_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid, cfg_ready, cfg_rx_en;
    logic [15:0] cfg_baud;
    logic        tx_valid, tx_ready, tx_last;
    logic [7:0]  tx_byte;
    logic        rx_valid, rx_ready;
    logic [7:0]  rx_byte;
    logic        intr_tx, intr_rx, intr_rx_empty;
    logic [11:0] reg_addr;
    logic [31:0] reg_wdata, reg_rdata;
    logic        reg_we, reg_re, busy, err;

    always #5 clk = ~clk;

    uart_reg_master #(
        .MAX_BURST(7),
        .READ_LAT(1)
`ifdef UART_MASTER_TIMEOUT_EN
        ,
        .TX_TIMEOUT(100)
`endif
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_baud_i(cfg_baud), .cfg_rx_en_i(cfg_rx_en),
        .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .tx_byte_i(tx_byte), .tx_last_i(tx_last),
        .rx_valid_o(rx_valid), .rx_ready_i(rx_ready), .rx_byte_o(rx_byte),
        .intr_tx_i(intr_tx), .intr_rx_i(intr_rx), .intr_rx_empty_i(intr_rx_empty),
        .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata),
        .reg_we_o(reg_we), .reg_re_o(reg_re), .reg_rdata_i(reg_rdata),
        .busy_o(busy), .err_o(err)
    );

    typedef struct packed {
        logic        is_wr;
        logic [11:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t       exp_q[$];
    logic [7:0] rx_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         tb_cnt   = 0;
    logic       prev_strobe = 1'b0;
    logic       bad_idle = 1'b0;
    acc_t       mon_acc;
    logic [7:0] mon_rx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Bus and RX-stream monitor: every strobe must match the next expected access.
    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_we || reg_re) begin
                check("strobe_gap", {31'h0, prev_strobe}, 32'h0);
                check("we_re_excl", {31'h0, reg_we & reg_re}, 32'h0);
                if (exp_q.size() == 0) begin
                    check("unexpected_access", {19'h0, reg_we, reg_addr}, 32'hFFFF_FFFF);
                end else begin
                    mon_acc = exp_q.pop_front();
                    check("acc_kind", {31'h0, reg_we}, {31'h0, mon_acc.is_wr});
                    check("acc_addr", {20'h0, reg_addr}, {20'h0, mon_acc.addr});
                    if (mon_acc.is_wr) check("acc_wdata", reg_wdata, mon_acc.data);
                end
            end else if (reg_addr != 12'h000 || reg_wdata != 32'h0) begin
                bad_idle = 1'b1;
            end
            if (rx_valid && rx_ready) begin
                if (rx_q.size() == 0) begin
                    check("rx_unexpected", {24'h0, rx_byte}, 32'hFFFF_FFFF);
                end else begin
                    mon_rx = rx_q.pop_front();
                    check("rx_byte", {24'h0, rx_byte}, {24'h0, mon_rx});
                end
            end
        end
        prev_strobe = reg_we | reg_re;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [11:0] a, input logic [31:0] d);
        exp_q.push_back({1'b1, a, d});
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        check(tag, exp_q.size(), 32'h0);
        exp_q.delete();
    endtask

    task automatic push_cfg(input logic [15:0] b, input logic en);
        push_wr(12'h000, {16'h0, b});
        push_wr(12'h00C, {31'h0, en});
        push_wr(12'h010, 32'h1);
        push_wr(12'h010, 32'h0);
        push_wr(12'h014, 32'h1);
        push_wr(12'h014, 32'h0);
    endtask

    task automatic do_cfg(input logic [15:0] b, input logic en);
        logic ok, saw;
        tick();
        push_cfg(b, en);
        cfg_valid = 1'b1; cfg_baud = b; cfg_rx_en = en;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cfg_ready) begin ok = 1'b1; break; end
        end
        check("cfg_accept", {31'h0, ok}, 32'h1);
        tick();
        cfg_valid = 1'b0; cfg_baud = 16'hDEAD;
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (cfg_ready) saw = 1'b1;
        end
        check("cfg_ready_low", {31'h0, saw}, 32'h0);
        @(negedge clk);
        check("cfg_idle_after", {31'h0, busy}, 32'h0);
        drain("cfg_drain");
    endtask

    task automatic finish_burst();
        push_wr(12'h018, tb_cnt);
        push_wr(12'h01C, 32'h1);
        drain("tx_kick_drain");
        repeat (3) tick();
        check("tx_wait_busy", {31'h0, busy}, 32'h1);
        intr_tx = 1'b1;
        push_wr(12'h01C, 32'h0);
        tick();
        intr_tx = 1'b0;
        drain("tx_done_drain");
        @(negedge clk);
        check("tx_idle_after", {31'h0, busy}, 32'h0);
        tb_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input logic auto_fin);
        logic ok;
        tick();
        push_wr(12'h004, {24'h0, b});
        tx_valid = 1'b1; tx_byte = b; tx_last = last;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_ready) begin ok = 1'b1; break; end
        end
        check("tx_accept", {31'h0, ok}, 32'h1);
        tick();
        tx_valid = 1'b0; tx_last = 1'b0;
        tb_cnt++;
        if (auto_fin && (last || tb_cnt == 7)) finish_burst();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got %0d expected 0", 1);
        $fatal(1);
    end

    initial begin
        logic ok, bad;
        rst_n = 1'b0;
        cfg_valid = 1'b0; cfg_baud = 16'h0; cfg_rx_en = 1'b0;
        tx_valid = 1'b0; tx_byte = 8'h0; tx_last = 1'b0;
        rx_ready = 1'b0; intr_tx = 1'b0; intr_rx = 1'b0; intr_rx_empty = 1'b1;
        reg_rdata = 32'h0;
        tx_valid = 1'b1;
        repeat (3) tick();
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_we", {31'h0, reg_we}, 32'h0);
        check("rst_re", {31'h0, reg_re}, 32'h0);
        check("rst_addr", {20'h0, reg_addr}, 32'h0);
        check("rst_wdata", reg_wdata, 32'h0);
        check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_tx_ready", {31'h0, tx_ready}, 32'h0);
        check("rst_cfg_ready", {31'h0, cfg_ready}, 32'h0);
        tx_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        do_cfg(16'd868, 1'b1);

        send_byte(8'hA5, 1'b0, 1'b1);
        send_byte(8'h5A, 1'b0, 1'b1);
        send_byte(8'h3C, 1'b1, 1'b1);

        for (int k = 0; k < 9; k++) send_byte(8'(k + 1), (k == 8), 1'b1);

        tick();
        reg_rdata = 32'h0000_00C3; intr_rx = 1'b1; intr_rx_empty = 1'b0;
        exp_q.push_back({1'b0, 12'h008, 32'h0});
        rx_q.push_back(8'hC3);
        drain("rx_read_drain");
        tick();
        intr_rx = 1'b0; intr_rx_empty = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_valid) begin ok = 1'b1; break; end
        end
        check("rx_valid_seen", {31'h0, ok}, 32'h1);
        reg_rdata = 32'h0;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!rx_valid || rx_byte !== 8'hC3) bad = 1'b1;
        end
        check("rx_hold_stable", {31'h0, bad}, 32'h0);
        tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        @(negedge clk);
        check("rx_idle_after", {31'h0, busy}, 32'h0);
        check("rx_q_empty", rx_q.size(), 32'h0);

        tick();
        push_cfg(16'd100, 1'b0);
        push_wr(12'h004, 32'h77);
        tb_cnt = 1;
        cfg_valid = 1'b1; cfg_baud = 16'd100; cfg_rx_en = 1'b0;
        tx_valid = 1'b1; tx_byte = 8'h77; tx_last = 1'b1;
        @(negedge clk);
        check("prio_cfg_ready", {31'h0, cfg_ready}, 32'h1);
        check("prio_tx_not_ready", {31'h0, tx_ready}, 32'h0);
        tick();
        cfg_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_ready) begin ok = 1'b1; break; end
        end
        check("prio_tx_accept", {31'h0, ok}, 32'h1);
        tick();
        tx_valid = 1'b0; tx_last = 1'b0;
        finish_burst();

        tick();
        intr_rx = 1'b1; intr_rx_empty = 1'b0;
        repeat (10) tick();
        check("rx_disabled_idle", {31'h0, busy}, 32'h0);
        intr_rx = 1'b0; intr_rx_empty = 1'b1;

        send_byte(8'h11, 1'b1, 1'b0);
        push_wr(12'h018, 32'h1);
        push_wr(12'h01C, 32'h1);
        drain("rst_kick_drain");
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_we", {31'h0, reg_we}, 32'h0);
        check("midrst_re", {31'h0, reg_re}, 32'h0);
        check("midrst_addr", {20'h0, reg_addr}, 32'h0);
        rst_n = 1'b1;
        tb_cnt = 0;
        send_byte(8'h21, 1'b0, 1'b1);
        send_byte(8'h22, 1'b1, 1'b1);

`ifdef UART_MASTER_TIMEOUT_EN
        send_byte(8'h33, 1'b1, 1'b0);
        push_wr(12'h018, 32'h1);
        push_wr(12'h01C, 32'h1);
        drain("to_kick_drain");
        push_wr(12'h01C, 32'h0);
        tb_cnt = 0;
        begin
            int n;
            n = 0;
            for (int i = 1; i <= 300; i++) begin
                @(negedge clk);
                if (err) begin n = i; break; end
            end
            check("timeout_cycles", n, 32'd101);
        end
        drain("to_done_drain");
        @(negedge clk);
        check("to_idle_after", {31'h0, busy}, 32'h0);
        check("to_err_sticky", {31'h0, err}, 32'h1);
        do_cfg(16'd868, 1'b1);
        check("to_err_cleared", {31'h0, err}, 32'h0);
`endif

        repeat (5) tick();
        check("final_exp_q_empty", exp_q.size(), 32'h0);
        check("idle_bus_zero", {31'h0, bad_idle}, 32'h0);
        check("final_err", {31'h0, err}, 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
